// File: rtl/xmatch_win_feeder.sv
`default_nettype none
// ============================================================================
// Module   : xmatch_win_feeder
// Brief    : Turns raster-order core/search pixel pairs into packed region and
//            centred core windows, one per valid search position.
// Revision : 1.0 - initial release
// ============================================================================
module xmatch_win_feeder #(
    parameter int DATA_DEPT = 4,
    parameter int REWIN_W   = 8,
    parameter int REWIN_H   = 8,
    parameter int COWIN_W   = 2,
    parameter int COWIN_H   = 2,
    parameter int IMG_W     = 64,
    parameter int IMG_H     = 48
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic                                 in_sof,
    input  logic [DATA_DEPT-1:0]                 in_core_px,
    input  logic [DATA_DEPT-1:0]                 in_reg_px,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [DATA_DEPT*COWIN_W*COWIN_H-1:0] coreWin,
    output logic [DATA_DEPT*REWIN_W*REWIN_H-1:0] RegionWin,
    output logic [$clog2(IMG_W)-1:0]             out_x,
    output logic [$clog2(IMG_H)-1:0]             out_y,
    output logic                                 out_eof,
    output logic                                 err_sync
);
    localparam int c_XW    = $clog2(IMG_W);
    localparam int c_YW    = $clog2(IMG_H);
    localparam int c_OFF_W = (REWIN_W - COWIN_W) / 2;
    localparam int c_OFF_H = (REWIN_H - COWIN_H) / 2;

    localparam logic [c_XW-1:0] c_X_LAST  = c_XW'(IMG_W - 1);
    localparam logic [c_YW-1:0] c_Y_LAST  = c_YW'(IMG_H - 1);
    localparam logic [c_XW-1:0] c_X_FIRST = c_XW'(REWIN_W - 1);
    localparam logic [c_YW-1:0] c_Y_FIRST = c_YW'(REWIN_H - 1);

    localparam logic [0:0] c_S_IDLE   = 1'b0;
    localparam logic [0:0] c_S_ACTIVE = 1'b1;

    logic [0:0]      r_state, w_stateNext;
    logic [c_XW-1:0] r_x, w_xNext, w_pxX;
    logic [c_YW-1:0] r_y, w_yNext, w_pxY;
    logic            w_accept, w_take, w_last, w_complete, w_errSet;

    // Line buffers: index 0 holds the oldest buffered row, REWIN_H-2 the previous row.
    logic [DATA_DEPT-1:0] r_regLine  [REWIN_H-1][IMG_W];
    logic [DATA_DEPT-1:0] r_coreLine [REWIN_H-1][IMG_W];
    logic [DATA_DEPT-1:0] r_regSh    [REWIN_H][REWIN_W];
    logic [DATA_DEPT-1:0] r_coreSh   [REWIN_H][REWIN_W];
    logic [DATA_DEPT-1:0] w_regCol   [REWIN_H];
    logic [DATA_DEPT-1:0] w_coreCol  [REWIN_H];
    logic [DATA_DEPT-1:0] w_regShNext  [REWIN_H][REWIN_W];
    logic [DATA_DEPT-1:0] w_coreShNext [REWIN_H][REWIN_W];
    logic [DATA_DEPT*REWIN_W*REWIN_H-1:0] w_regWin;
    logic [DATA_DEPT*COWIN_W*COWIN_H-1:0] w_coreWin;

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_stateNext;
            r_x     <= w_xNext;
            r_y     <= w_yNext;
        end
    end

    always_comb begin
        w_accept    = in_valid && in_ready;
        w_stateNext = r_state;
        w_xNext     = r_x;
        w_yNext     = r_y;
        w_pxX       = r_x;
        w_pxY       = r_y;
        w_take      = 1'b0;
        w_errSet    = 1'b0;
        w_last      = 1'b0;
        if (w_accept) begin
            if (in_sof) begin
                // A start-of-frame always restarts at (0,0); mid-frame it is also a sync error.
                w_pxX       = '0;
                w_pxY       = '0;
                w_take      = 1'b1;
                w_errSet    = (r_state == c_S_ACTIVE);
                w_stateNext = c_S_ACTIVE;
            end else if (r_state == c_S_IDLE) begin
                w_errSet = 1'b1;
            end else begin
                w_take = 1'b1;
            end
            if (w_take) begin
                w_last = (w_pxX == c_X_LAST) && (w_pxY == c_Y_LAST);
                if (w_pxX == c_X_LAST) begin
                    w_xNext = '0;
                    w_yNext = w_last ? '0 : w_pxY + c_YW'(1);
                end else begin
                    w_xNext = w_pxX + c_XW'(1);
                    w_yNext = w_pxY;
                end
                if (w_last) begin
                    w_stateNext = c_S_IDLE;
                end
            end
        end
        w_complete = w_take && (w_pxX >= c_X_FIRST) && (w_pxY >= c_Y_FIRST);
    end

    always_comb begin
        for (int r = 0; r < REWIN_H - 1; r++) begin
            w_regCol[r]  = r_regLine[r][w_pxX];
            w_coreCol[r] = r_coreLine[r][w_pxX];
        end
        w_regCol[REWIN_H-1]  = in_reg_px;
        w_coreCol[REWIN_H-1] = in_core_px;
        for (int r = 0; r < REWIN_H; r++) begin
            for (int c = 0; c < REWIN_W - 1; c++) begin
                w_regShNext[r][c]  = r_regSh[r][c+1];
                w_coreShNext[r][c] = r_coreSh[r][c+1];
            end
            w_regShNext[r][REWIN_W-1]  = w_regCol[r];
            w_coreShNext[r][REWIN_W-1] = w_coreCol[r];
        end
        w_regWin  = '0;
        w_coreWin = '0;
        for (int r = 0; r < REWIN_H; r++) begin
            for (int c = 0; c < REWIN_W; c++) begin
                w_regWin[DATA_DEPT*(r*REWIN_W+c) +: DATA_DEPT] = w_regShNext[r][c];
            end
        end
        for (int r = 0; r < COWIN_H; r++) begin
            for (int c = 0; c < COWIN_W; c++) begin
                w_coreWin[DATA_DEPT*(r*COWIN_W+c) +: DATA_DEPT] = w_coreShNext[c_OFF_H+r][c_OFF_W+c];
            end
        end
    end

    // Storage needs no reset: stale contents only ever feed windows that are never emitted.
    always_ff @(posedge clk) begin
        if (w_take) begin
            for (int r = 0; r < REWIN_H - 2; r++) begin
                r_regLine[r][w_pxX]  <= r_regLine[r+1][w_pxX];
                r_coreLine[r][w_pxX] <= r_coreLine[r+1][w_pxX];
            end
            r_regLine[REWIN_H-2][w_pxX]  <= in_reg_px;
            r_coreLine[REWIN_H-2][w_pxX] <= in_core_px;
            r_regSh  <= w_regShNext;
            r_coreSh <= w_coreShNext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_eof   <= 1'b0;
            err_sync  <= 1'b0;
            coreWin   <= '0;
            RegionWin <= '0;
        end else begin
            if (w_complete) begin
                out_valid <= 1'b1;
                RegionWin <= w_regWin;
                coreWin   <= w_coreWin;
                out_x     <= w_pxX - c_X_FIRST;
                out_y     <= w_pxY - c_Y_FIRST;
                out_eof   <= w_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (w_errSet) begin
                err_sync <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_xmatch_win_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_xmatch_win_feeder
// Brief    : Scoreboard bench for xmatch_win_feeder against an image-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xmatch_win_feeder;
    localparam int DD = 8, RW = 8, RH = 8, CW = 2, CH = 2, IW = 16, IH = 12;
    localparam int OFFW = (RW - CW) / 2, OFFH = (RH - CH) / 2;

    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b1;
    logic [DD-1:0] in_core_px = '0, in_reg_px = '0;
    logic in_ready, out_valid, out_eof, err_sync;
    logic [DD*CW*CH-1:0] coreWin;
    logic [DD*RW*RH-1:0] RegionWin;
    logic [3:0] out_x, out_y;

    xmatch_win_feeder #(
        .DATA_DEPT(DD), .REWIN_W(RW), .REWIN_H(RH), .COWIN_W(CW), .COWIN_H(CH),
        .IMG_W(IW), .IMG_H(IH)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
        .in_core_px(in_core_px), .in_reg_px(in_reg_px), .out_valid(out_valid),
        .out_ready(out_ready), .coreWin(coreWin), .RegionWin(RegionWin),
        .out_x(out_x), .out_y(out_y), .out_eof(out_eof), .err_sync(err_sync)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DD*RW*RH-1:0] regW;
        logic [DD*CW*CH-1:0] coreW;
        logic [3:0]          x;
        logic [3:0]          y;
        logic                eof;
    } win_t;

    win_t expQ[$];
    int   tests = 0, fails = 0;
    int   winCount = 0, eofCount = 0;
    win_t firstWin, lastWin;
    logic [DD-1:0] srch [IH][IW];
    logic [DD-1:0] coreImg [IH][IW];
    bit   mIdle = 1'b1, expErr = 1'b0;
    int   mx = 0, my = 0;
    bit   readyRand = 1'b0, gaps = 1'b0;
    int   holdCnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: remember each frame as a 2D image, cut windows straight out of it.
    task automatic modelAccept(input bit sof, input logic [DD-1:0] cpx, input logic [DD-1:0] spx);
        bit   take;
        win_t e;
        take = 1'b1;
        if (sof) begin
            if (!mIdle) expErr = 1'b1;
            mx = 0; my = 0; mIdle = 1'b0;
        end else if (mIdle) begin
            expErr = 1'b1;
            take = 1'b0;
        end
        if (take) begin
            srch[my][mx]    = spx;
            coreImg[my][mx] = cpx;
            if (mx >= RW - 1 && my >= RH - 1) begin
                e = '0;
                for (int r = 0; r < RH; r++)
                    for (int c = 0; c < RW; c++)
                        e.regW[DD*(r*RW+c) +: DD] = srch[my-RH+1+r][mx-RW+1+c];
                for (int r = 0; r < CH; r++)
                    for (int c = 0; c < CW; c++)
                        e.coreW[DD*(r*CW+c) +: DD] = coreImg[my-RH+1+OFFH+r][mx-RW+1+OFFW+c];
                e.x   = 4'(mx - RW + 1);
                e.y   = 4'(my - RH + 1);
                e.eof = (mx == IW - 1) && (my == IH - 1);
                expQ.push_back(e);
            end
            mx++;
            if (mx == IW) begin
                mx = 0; my++;
                if (my == IH) begin my = 0; mIdle = 1'b1; end
            end
        end
    endtask

    task automatic modelReset();
        expQ.delete();
        mIdle = 1'b1; mx = 0; my = 0; expErr = 1'b0;
    endtask

    initial begin : readyDriver
        forever begin
            @(negedge clk);
            if (holdCnt > 0) begin
                out_ready = 1'b0;
                holdCnt--;
            end else if (readyRand) out_ready = ($urandom_range(0, 3) != 0);
            else out_ready = 1'b1;
        end
    end

    initial begin : monitor
        win_t act, e, prev;
        bit   prevStall;
        prevStall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                prevStall = 1'b0;
                continue;
            end
            act = {RegionWin, coreWin, out_x, out_y, out_eof};
            if (prevStall) begin
                tests++;
                if (!out_valid || act !== prev) begin
                    fails++;
                    $display("FAIL stall hold: got valid=%0b x=%0d y=%0d, expected valid=1 x=%0d y=%0d unchanged",
                             out_valid, act.x, act.y, prev.x, prev.y);
                end
            end
            if (out_valid && !out_ready) check("in_ready during stall", in_ready, 0);
            if (out_valid && out_ready) begin
                tests++;
                if (expQ.size() == 0) begin
                    fails++;
                    $display("FAIL window: got unexpected x=%0d y=%0d eof=%0b, expected no window", act.x, act.y, act.eof);
                end else begin
                    e = expQ.pop_front();
                    if (act !== e) begin
                        fails++;
                        $display("FAIL window: got x=%0d y=%0d eof=%0b reg=%h core=%h, expected x=%0d y=%0d eof=%0b reg=%h core=%h",
                                 act.x, act.y, act.eof, act.regW, act.coreW, e.x, e.y, e.eof, e.regW, e.coreW);
                    end
                end
                if (winCount == 0) firstWin = act;
                lastWin = act;
                winCount++;
                if (act.eof) eofCount++;
            end
            prevStall = out_valid && !out_ready;
            prev = act;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sof   = 1'b0;
        end
    endtask

    task automatic sendPx(input bit sof, input logic [DD-1:0] cpx, input logic [DD-1:0] spx);
        if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        @(negedge clk);
        in_valid = 1'b1; in_sof = sof; in_core_px = cpx; in_reg_px = spx;
        for (int t = 0; t < 2000; t++) begin
            #4;
            if (in_ready) begin
                modelAccept(sof, cpx, spx);
                @(posedge clk);
                return;
            end
            @(negedge clk);
        end
        fails++;
        $display("FAIL accept: in_ready got 0, expected 1 within 2000 cycles");
        $fatal(1, "accept timeout");
    endtask

    task automatic sendFrame(input bit pattern, input int nPx, input int abortWin);
        for (int p = 0; p < nPx; p++) begin
            logic [DD-1:0] s, cv;
            if (abortWin >= 0 && winCount >= abortWin) return;
            if (pattern) begin
                s = 8'(p); cv = 8'(255 - p);
            end else begin
                s = 8'($urandom); cv = 8'($urandom);
            end
            sendPx(p == 0, cv, s);
        end
    endtask

    task automatic drain();
        idle(1);
        for (int t = 0; t < 600 && expQ.size() != 0; t++) @(negedge clk);
        check("drain pending windows", expQ.size(), 0);
        idle(2);
    endtask

    task automatic clearCounts();
        winCount = 0; eofCount = 0;
    endtask

    task automatic hardReset();
        @(negedge clk);
        rst = 1'b1;
        modelReset();
        idle(2);
        rst = 1'b0;
    endtask

    initial begin : main
        int nPart, expPart;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #4;
        check("reset out_valid", out_valid, 0);
        check("reset out_eof", out_eof, 0);
        check("reset err_sync", err_sync, 0);
        check("reset in_ready", in_ready, 1);
        check("reset out_xy", {out_x, out_y}, 0);
        check("reset windows", {|RegionWin, |coreWin}, 0);

        // Ramp frame with full downstream throughput
        clearCounts();
        sendFrame(1'b1, IW * IH, -1);
        drain();
        check("t1 first x", firstWin.x, 0);
        check("t1 first y", firstWin.y, 0);
        check("t1 first reg byte0", firstWin.regW[7:0], 0);
        check("t1 first reg top", firstWin.regW[DD*RW*RH-1 -: 8], 119);
        check("t1 first core byte0", firstWin.coreW[7:0], 204);
        check("t2 window count", winCount, 45);
        check("t2 eof count", eofCount, 1);
        check("t2 last eof", lastWin.eof, 1);
        check("t2 last xy", {lastWin.x, lastWin.y}, {4'd8, 4'd4});
        check("t2 last reg top", lastWin.regW[DD*RW*RH-1 -: 8], 191);
        check("t2 err_sync", err_sync, expErr);

        // Ten-cycle downstream stall mid-frame
        clearCounts();
        fork
            sendFrame(1'b1, IW * IH, -1);
            begin
                for (int t = 0; t < 5000 && winCount < 10; t++) @(negedge clk);
                holdCnt = 10;
            end
        join
        drain();
        check("t3 window count", winCount, 45);
        check("t3 eof count", eofCount, 1);
        check("t3 last xy", {lastWin.x, lastWin.y}, {4'd8, 4'd4});

        // Start-of-frame arriving at pixel (5,3)
        clearCounts();
        sendFrame(1'b1, 3 * IW + 5, -1);
        sendFrame(1'b1, IW * IH, -1);
        drain();
        check("t4 err_sync", err_sync, 1);
        check("t4 first xy", {firstWin.x, firstWin.y}, 0);
        check("t4 window count", winCount, 45);

        // Pixels before any start-of-frame are discarded
        hardReset();
        #4;
        check("t5 err after reset", err_sync, 0);
        clearCounts();
        for (int i = 0; i < 3; i++) sendPx(1'b0, 8'($urandom), 8'($urandom));
        idle(1);
        #4;
        check("t5 err_sync", err_sync, 1);
        sendFrame(1'b1, IW * IH, -1);
        drain();
        check("t5 window count", winCount, 45);

        // Asynchronous reset while window 20 is being presented
        clearCounts();
        sendFrame(1'b1, IW * IH, 20);
        check("t6 reached window 20", winCount >= 20, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("t6 async out_valid", out_valid, 0);
        check("t6 async err_sync", err_sync, 0);
        modelReset();
        idle(2);
        rst = 1'b0;
        clearCounts();
        sendFrame(1'b1, IW * IH, -1);
        drain();
        check("t6 window count", winCount, 45);
        check("t6 eof count", eofCount, 1);

        // Random pixels, random gaps and backpressure, truncated frame in between
        readyRand = 1'b1;
        gaps = 1'b1;
        hardReset();
        clearCounts();
        nPart = $urandom_range(20, 150);
        expPart = 0;
        for (int p = 0; p < nPart; p++) if (p % IW >= RW - 1 && p / IW >= RH - 1) expPart++;
        sendFrame(1'b0, IW * IH, -1);
        sendFrame(1'b0, nPart, -1);
        sendFrame(1'b0, IW * IH, -1);
        drain();
        check("rand window count", winCount, 90 + expPart);
        check("rand eof count", eofCount, 2);
        check("rand err_sync", err_sync, expErr);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
